branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit.sv | 182 ++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Two-slot in-order branch resolution unit.
// Branches are queued with their operands. Operands that are not ready are
// filled from the common data bus. The head branch is resolved by a small FSM
// that emits a one-cycle pcChange pulse and a registered redirect value.
module branch_resolve_unit #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             issueValid,
  output logic             issueReady,
  input  logic [31:0]      issuePc,
  input  logic [31:0]      issueImm,
  input  logic [2:0]       issueFunct3,
  input  logic             rs1Ready,
  input  logic             rs2Ready,
  input  logic [31:0]      rs1Value,
  input  logic [31:0]      rs2Value,
  input  logic [TAG_W-1:0] rs1Tag,
  input  logic [TAG_W-1:0] rs2Tag,
  input  logic             cdbValid,
  input  logic [TAG_W-1:0] cdbTag,
  input  logic [31:0]      cdbData,
  output logic             pcChange,
  output logic [31:0]      changeData,
  output logic             bneempty,
  output logic             nobranch
);

  typedef struct packed {
    logic             rdy;
    logic [31:0]      val;
    logic [TAG_W-1:0] tag;
  } opnd_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  funct3;
    opnd_t       rs1;
    opnd_t       rs2;
  } slot_t;

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_PULSE, S_GAP} state_e;

  state_e      state_q, state_d;
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic [1:0]  count_q, count_d;
  slot_t       slots_q [DEPTH];
  slot_t       slots_d [DEPTH];
  logic        pc_change_q, pc_change_d;
  logic [31:0] change_data_q, change_data_d;

  logic        issue_ready;
  logic        alloc;
  logic        free_head;
  slot_t       head_slot;
  logic        head_rdy;
  logic        taken;
  logic [31:0] target;

  // An operand waiting on a tag picks up a matching CDB broadcast. The same
  // function serves both queued operands and the same-cycle bypass at issue.
  function automatic opnd_t snoop(input opnd_t o, input logic cv,
                                  input logic [TAG_W-1:0] ct,
                                  input logic [31:0] cd);
    opnd_t r;
    r = o;
    if (cv && !o.rdy && (o.tag == ct)) begin
      r.rdy = 1'b1;
      r.val = cd;
    end
    return r;
  endfunction

  assign issue_ready = (count_q != 2'(DEPTH));
  assign alloc       = issueValid && issue_ready;
  assign free_head   = (state_q == S_PULSE);
  assign head_slot   = slots_q[head_q];
  assign head_rdy    = head_slot.valid && head_slot.rs1.rdy && head_slot.rs2.rdy;

  // Branch condition and redirect target for the head slot.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and no latch is inferred.
    taken = 1'b0;
    unique case (head_slot.funct3)
      3'b000:  taken = (head_slot.rs1.val == head_slot.rs2.val);
      3'b001:  taken = (head_slot.rs1.val != head_slot.rs2.val);
      3'b100:  taken = ($signed(head_slot.rs1.val) <  $signed(head_slot.rs2.val));
      3'b101:  taken = ($signed(head_slot.rs1.val) >= $signed(head_slot.rs2.val));
      3'b110:  taken = (head_slot.rs1.val <  head_slot.rs2.val);
      3'b111:  taken = (head_slot.rs1.val >= head_slot.rs2.val);
      default: taken = 1'b0;
    endcase
    target = taken ? (head_slot.pc + head_slot.imm) : (head_slot.pc + 32'd4);
  end

  // Slot FIFO: CDB capture, allocation at the tail, release of the head.
  always_comb begin
    slots_d = slots_q;
    head_d  = head_q;
    tail_d  = tail_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (slots_q[i].valid) begin
        slots_d[i].rs1 = snoop(slots_q[i].rs1, cdbValid, cdbTag, cdbData);
        slots_d[i].rs2 = snoop(slots_q[i].rs2, cdbValid, cdbTag, cdbData);
      end
    end
    if (free_head) begin
      slots_d[head_q].valid = 1'b0;
      head_d = head_q + 1'b1;
    end
    // The tail slot is always empty when issue_ready is high, so it never
    // collides with the head being released on the same edge.
    if (alloc) begin
      slots_d[tail_q].valid  = 1'b1;
      slots_d[tail_q].pc     = issuePc;
      slots_d[tail_q].imm    = issueImm;
      slots_d[tail_q].funct3 = issueFunct3;
      slots_d[tail_q].rs1    = snoop('{rdy: rs1Ready, val: rs1Value, tag: rs1Tag},
                                     cdbValid, cdbTag, cdbData);
      slots_d[tail_q].rs2    = snoop('{rdy: rs2Ready, val: rs2Value, tag: rs2Tag},
                                     cdbValid, cdbTag, cdbData);
      tail_d = tail_q + 1'b1;
    end
    count_d = count_q + {1'b0, alloc} - {1'b0, free_head};
  end

  // Resolution FSM: IDLE -> EVAL -> PULSE -> GAP -> IDLE.
  always_comb begin
    state_d       = state_q;
    pc_change_d   = pc_change_q;
    change_data_d = change_data_q;
    unique case (state_q)
      S_IDLE:  if (head_rdy) state_d = S_EVAL;
      S_EVAL: begin
        change_data_d = target - 32'd4;
        pc_change_d   = 1'b1;
        state_d       = S_PULSE;
      end
      S_PULSE: begin
        pc_change_d = 1'b0;
        state_d     = S_GAP;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!resetn) begin
      state_q       <= S_IDLE;
      head_q        <= 1'b0;
      tail_q        <= 1'b0;
      count_q       <= 2'd0;
      pc_change_q   <= 1'b0;
      change_data_q <= 32'd0;
      // NOTE: only the valid bits are reset; slot payload is ignored while invalid and needs no reset.
      for (int i = 0; i < DEPTH; i++) slots_q[i].valid <= 1'b0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      pc_change_q   <= pc_change_d;
      change_data_q <= change_data_d;
      slots_q       <= slots_d;
    end
  end

  assign issueReady = issue_ready;
  assign pcChange   = pc_change_q;
  assign changeData = change_data_q;
  assign bneempty   = (count_q == 2'd0);
  assign nobranch   = (count_q == 2'd0) && (state_q == S_IDLE);

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: a table of single-branch
// vectors plus directed sequences for CDB capture, full queue, simultaneous
// allocate/free and reset during a pulse.
module tb_branch_resolve_unit;

  localparam int TAG_W = 4;

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic             issueValid = 1'b0;
  logic             issueReady;
  logic [31:0]      issuePc = '0;
  logic [31:0]      issueImm = '0;
  logic [2:0]       issueFunct3 = '0;
  logic             rs1Ready = 1'b0;
  logic             rs2Ready = 1'b0;
  logic [31:0]      rs1Value = '0;
  logic [31:0]      rs2Value = '0;
  logic [TAG_W-1:0] rs1Tag = '0;
  logic [TAG_W-1:0] rs2Tag = '0;
  logic             cdbValid = 1'b0;
  logic [TAG_W-1:0] cdbTag = '0;
  logic [31:0]      cdbData = '0;
  logic             pcChange;
  logic [31:0]      changeData;
  logic             bneempty;
  logic             nobranch;

  branch_resolve_unit #(.TAG_W(TAG_W), .DEPTH(2)) dut (
    .clock(clock), .resetn(resetn),
    .issueValid(issueValid), .issueReady(issueReady),
    .issuePc(issuePc), .issueImm(issueImm), .issueFunct3(issueFunct3),
    .rs1Ready(rs1Ready), .rs2Ready(rs2Ready),
    .rs1Value(rs1Value), .rs2Value(rs2Value),
    .rs1Tag(rs1Tag), .rs2Tag(rs2Tag),
    .cdbValid(cdbValid), .cdbTag(cdbTag), .cdbData(cdbData),
    .pcChange(pcChange), .changeData(changeData),
    .bneempty(bneempty), .nobranch(nobranch)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    bit          byp;   // rs1 delivered by same-cycle CDB bypass
    logic [31:0] exp;   // expected changeData
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_in();
    issueValid = 1'b0;
    cdbValid   = 1'b0;
    rs1Ready   = 1'b0;
    rs2Ready   = 1'b0;
  endtask

  task automatic set_branch(input logic [31:0] pc, input logic [31:0] imm,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b);
    issueValid  = 1'b1;
    issuePc     = pc;
    issueImm    = imm;
    issueFunct3 = f3;
    rs1Ready    = 1'b1;
    rs1Value    = a;
    rs1Tag      = '0;
    rs2Ready    = 1'b1;
    rs2Value    = b;
    rs2Tag      = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!nobranch && n < 20) begin
      step();
      n++;
    end
    check("idle_timeout", {31'd0, nobranch}, 32'd1);
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      step();
      if (pcChange) pulses++;
    end
  endtask

  initial begin
    int pulses;

    //          pc            imm           f3      rs1           rs2           byp   exp
    vecs[0]  = '{32'h0000_0100, 32'h0000_0020, 3'b001, 32'd5,        32'd7,        1'b0, 32'h0000_011C};
    vecs[1]  = '{32'h0000_0200, 32'h0000_0040, 3'b000, 32'd1,        32'd2,        1'b0, 32'h0000_0200};
    vecs[2]  = '{32'h0000_0300, 32'hFFFF_FFF0, 3'b000, 32'd9,        32'd9,        1'b0, 32'h0000_02EC};
    vecs[3]  = '{32'h0000_0400, 32'h0000_0080, 3'b100, 32'hFFFF_FFFE, 32'd3,       1'b0, 32'h0000_047C};
    vecs[4]  = '{32'h0000_0500, 32'h0000_0080, 3'b110, 32'hFFFF_FFFE, 32'd3,       1'b0, 32'h0000_0500};
    vecs[5]  = '{32'h0000_0600, 32'h0000_0010, 3'b101, 32'd3,        32'd3,        1'b0, 32'h0000_060C};
    vecs[6]  = '{32'h0000_0700, 32'h0000_0010, 3'b111, 32'd2,        32'hFFFF_FFFF, 1'b0, 32'h0000_0700};
    vecs[7]  = '{32'h0000_0800, 32'h0000_0100, 3'b010, 32'd4,        32'd4,        1'b0, 32'h0000_0800};
    vecs[8]  = '{32'h0000_0900, 32'h0000_0100, 3'b011, 32'd4,        32'd8,        1'b0, 32'h0000_0900};
    vecs[9]  = '{32'hFFFF_FFF0, 32'h0000_0020, 3'b001, 32'd1,        32'd2,        1'b0, 32'h0000_000C};
    vecs[10] = '{32'h0000_0B00, 32'h0000_0020, 3'b111, 32'hFFFF_FFFF, 32'd1,       1'b1, 32'h0000_0B1C};
    vecs[11] = '{32'h0000_0C00, 32'h0000_0020, 3'b101, 32'hFFFF_FFFF, 32'd1,       1'b1, 32'h0000_0C00};

    // Reset state.
    step();
    step();
    resetn = 1'b1;
    check("rst_pcChange",   {31'd0, pcChange},   32'd0);
    check("rst_changeData", changeData,          32'd0);
    check("rst_issueReady", {31'd0, issueReady}, 32'd1);
    check("rst_bneempty",   {31'd0, bneempty},   32'd1);
    check("rst_nobranch",   {31'd0, nobranch},   32'd1);

    // Single-branch vectors: pulse on the third edge after allocation.
    for (int i = 0; i < 12; i++) begin
      wait_idle();
      set_branch(vecs[i].pc, vecs[i].imm, vecs[i].f3, vecs[i].rs1, vecs[i].rs2);
      if (vecs[i].byp) begin
        rs1Ready = 1'b0;
        rs1Tag   = 4'd6;
        rs1Value = 32'd0;
        cdbValid = 1'b1;
        cdbTag   = 4'd6;
        cdbData  = vecs[i].rs1;
      end
      step();
      clear_in();
      check($sformatf("v%0d_e0_pc", i),  {31'd0, pcChange}, 32'd0);
      check($sformatf("v%0d_e0_empty", i), {31'd0, bneempty}, 32'd0);
      step();
      check($sformatf("v%0d_e1_pc", i),  {31'd0, pcChange}, 32'd0);
      step();
      check($sformatf("v%0d_e2_pc", i),  {31'd0, pcChange}, 32'd1);
      check($sformatf("v%0d_data", i),   changeData, vecs[i].exp);
      step();
      check($sformatf("v%0d_e3_pc", i),  {31'd0, pcChange}, 32'd0);
      check($sformatf("v%0d_hold", i),   changeData, vecs[i].exp);
      check($sformatf("v%0d_e3_empty", i), {31'd0, bneempty}, 32'd1);
      check($sformatf("v%0d_e3_nob", i), {31'd0, nobranch}, 32'd0);
      step();
      check($sformatf("v%0d_e4_nob", i), {31'd0, nobranch}, 32'd1);
    end

    // CDB capture: BLT waits on tag 3; a non-matching tag is ignored.
    wait_idle();
    set_branch(32'h0000_0A00, 32'h0000_0040, 3'b100, 32'd0, 32'd1);
    rs1Ready = 1'b0;
    rs1Tag   = 4'd3;
    step();                                   // edge 0: allocate
    clear_in();
    check("cdb_e0_pc", {31'd0, pcChange}, 32'd0);
    step();
    check("cdb_e1_pc", {31'd0, pcChange}, 32'd0);
    cdbValid = 1'b1; cdbTag = 4'd5; cdbData = 32'd5;
    step();
    cdbValid = 1'b0;
    check("cdb_e2_pc", {31'd0, pcChange}, 32'd0);
    step();
    check("cdb_e3_pc", {31'd0, pcChange}, 32'd0);
    cdbValid = 1'b1; cdbTag = 4'd3; cdbData = 32'hFFFF_FFFF;
    step();                                   // edge 4: capture
    cdbValid = 1'b0;
    check("cdb_k_pc", {31'd0, pcChange}, 32'd0);
    step();
    check("cdb_k1_pc", {31'd0, pcChange}, 32'd0);
    step();
    check("cdb_k2_pc", {31'd0, pcChange}, 32'd1);
    check("cdb_data", changeData, 32'h0000_0A3C);
    step();
    check("cdb_k3_pc", {31'd0, pcChange}, 32'd0);

    // Full queue: two back-to-back branches, a third issue is ignored.
    wait_idle();
    set_branch(32'h0000_0D00, 32'h0000_0010, 3'b001, 32'd1, 32'd2);
    step();                                   // edge 0: A
    set_branch(32'h0000_0E00, 32'h0000_0008, 3'b000, 32'd1, 32'd1);
    step();                                   // edge 1: B
    check("full_ready", {31'd0, issueReady}, 32'd0);
    set_branch(32'h0000_0F00, 32'h0000_0010, 3'b001, 32'd1, 32'd2);
    step();                                   // edge 2: C ignored
    check("full_ready2", {31'd0, issueReady}, 32'd0);
    check("full_pulseA", {31'd0, pcChange},   32'd1);
    check("full_dataA",  changeData,          32'h0000_0D0C);
    step();                                   // edge 3: A freed, C ignored
    clear_in();
    check("full_ready_rise", {31'd0, issueReady}, 32'd1);
    check("full_e3_pc", {31'd0, pcChange}, 32'd0);
    step();
    check("full_e4_pc", {31'd0, pcChange}, 32'd0);
    step();
    check("full_e5_pc", {31'd0, pcChange}, 32'd0);
    step();
    check("full_pulseB", {31'd0, pcChange}, 32'd1);
    check("full_dataB",  changeData,        32'h0000_0E04);
    step();
    check("full_e7_pc", {31'd0, pcChange}, 32'd0);
    check("full_empty", {31'd0, bneempty}, 32'd1);
    count_pulses(8, pulses);
    check("full_no_third", pulses, 32'd0);

    // Allocate on the same edge as the head is freed.
    wait_idle();
    set_branch(32'h0000_1000, 32'h0000_0010, 3'b000, 32'd3, 32'd4);
    step();                                   // edge 0: X
    clear_in();
    step();
    step();                                   // X pulsing
    set_branch(32'h0000_1100, 32'h0000_0030, 3'b001, 32'd3, 32'd4);
    step();                                   // edge 3: free X, allocate Y
    clear_in();
    check("swap_empty", {31'd0, bneempty},   32'd0);
    check("swap_ready", {31'd0, issueReady}, 32'd1);
    step();
    step();
    step();
    check("swap_pulseY", {31'd0, pcChange}, 32'd1);
    check("swap_dataY",  changeData,        32'h0000_112C);

    // Reset while a pulse is high with a second branch still queued.
    wait_idle();
    set_branch(32'h0000_2000, 32'h0000_0010, 3'b001, 32'd1, 32'd2);
    step();
    set_branch(32'h0000_2100, 32'h0000_0010, 3'b001, 32'd1, 32'd2);
    step();
    clear_in();
    step();
    check("rstp_pulse", {31'd0, pcChange}, 32'd1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("rstp_pc",    {31'd0, pcChange},   32'd0);
    check("rstp_data",  changeData,          32'd0);
    check("rstp_empty", {31'd0, bneempty},   32'd1);
    check("rstp_nob",   {31'd0, nobranch},   32'd1);
    check("rstp_ready", {31'd0, issueReady}, 32'd1);
    count_pulses(10, pulses);
    check("rstp_no_pulse", pulses, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
